// File: rtl/des_region_scheduler.sv
// Sweeps region_first..region_last over NUM_BLOCKS des_block workers, one dispatch
// and one capture per cycle at most, and accumulates every captured worker counter.
module des_region_scheduler #(
  parameter int NUM_BLOCKS = 4,
  parameter int CNT_W      = 10,
  parameter int ACC_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [15:0]                 region_first,
  input  logic [15:0]                 region_last,
  output logic [NUM_BLOCKS-1:0]       blk_start,
  output logic [16*NUM_BLOCKS-1:0]    blk_region,
  input  logic [CNT_W*NUM_BLOCKS-1:0] blk_counter,
  input  logic [NUM_BLOCKS-1:0]       blk_valid,
  output logic [ACC_W-1:0]            total,
  output logic [16:0]                 regions_done,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} top_state_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_REL = 2'd2} slot_state_e;

  top_state_e                  state_q;
  slot_state_e                 slot_q [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0]       rel_q;
  logic [15:0]                 last_q;
  logic [16:0]                 next_region_q;
  logic [NUM_BLOCKS-1:0]       blk_start_q;
  logic [16*NUM_BLOCKS-1:0]    blk_region_q;
  logic [ACC_W-1:0]            total_q;
  logic [16:0]                 regions_done_q;
  logic                        busy_q;
  logic                        done_q;

  logic [NUM_BLOCKS-1:0]       disp_sel_s;
  logic [NUM_BLOCKS-1:0]       cap_sel_s;
  logic [CNT_W-1:0]            cap_cnt_s;
  logic                        all_idle_s;
  logic                        more_s;

  assign blk_start    = blk_start_q;
  assign blk_region   = blk_region_q;
  assign total        = total_q;
  assign regions_done = regions_done_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // 17-bit compare so a sweep ending at 16'hFFFF stops instead of wrapping
  assign more_s = (next_region_q <= {1'b0, last_q});

  // Lowest-index free slot for dispatch and lowest-index valid running slot for capture
  always_comb begin
    disp_sel_s = '0;
    cap_sel_s  = '0;
    cap_cnt_s  = '0;
    all_idle_s = 1'b1;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (slot_q[i] == S_IDLE) begin
        disp_sel_s    = '0;
        disp_sel_s[i] = 1'b1;
      end else begin
        all_idle_s = 1'b0;
      end
      if ((slot_q[i] == S_RUN) && blk_valid[i]) begin
        cap_sel_s    = '0;
        cap_sel_s[i] = 1'b1;
        cap_cnt_s    = blk_counter[i*CNT_W +: CNT_W];
      end else begin
        cap_cnt_s = cap_cnt_s;
      end
    end
  end

  // Top sweep FSM together with the per-slot worker handshake FSMs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rel_q          <= '0;
      last_q         <= 16'd0;
      next_region_q  <= 17'd0;
      blk_start_q    <= '0;
      blk_region_q   <= '0;
      total_q        <= '0;
      regions_done_q <= 17'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        slot_q[i] <= S_IDLE;
      end
    end else begin
      // Released slots keep start low for two cycles before becoming free
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        if (slot_q[i] == S_REL) begin
          if (rel_q[i]) slot_q[i] <= S_IDLE;
          rel_q[i] <= ~rel_q[i];
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (start && all_idle_s) begin
            last_q         <= region_last;
            next_region_q  <= {1'b0, region_first};
            total_q        <= '0;
            regions_done_q <= 17'd0;
            if (region_first > region_last) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!start) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            blk_start_q <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
              if (slot_q[i] != S_REL) begin
                slot_q[i] <= S_REL;
                rel_q[i]  <= 1'b0;
              end
            end
          end else begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
              if (cap_sel_s[i]) begin
                blk_start_q[i] <= 1'b0;
                slot_q[i]      <= S_REL;
                rel_q[i]       <= 1'b0;
              end
              if (disp_sel_s[i] && more_s) begin
                blk_start_q[i]          <= 1'b1;
                blk_region_q[16*i +: 16] <= next_region_q[15:0];
                slot_q[i]               <= S_RUN;
              end
            end
            if (cap_sel_s != '0) begin
              total_q        <= total_q + {{(ACC_W-CNT_W){1'b0}}, cap_cnt_s};
              regions_done_q <= regions_done_q + 17'd1;
            end
            if (more_s && (disp_sel_s != '0)) next_region_q <= next_region_q + 17'd1;
            if (!more_s && all_idle_s) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!start) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/des_region_scheduler.md
DES_REGION_SCHEDULER -- requirements
Module: des_region_scheduler

Interface
REQ-001 Parameter NUM_BLOCKS, default 4, number of attached des_block workers (1..8).
REQ-002 Parameter CNT_W, default 10, width of each worker counter.
REQ-003 Parameter ACC_W, default 32, width of the total accumulator.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous reset, active high.
REQ-007 start  input  1  host run request; level-sensitive; dropping it aborts or acknowledges completion.
REQ-008 region_first  input  16  first region_select value in the sweep, inclusive.
REQ-009 region_last  input  16  last region_select value in the sweep, inclusive.
REQ-010 blk_start  output  NUM_BLOCKS  per-worker start level.
REQ-011 blk_region  output  16*NUM_BLOCKS  per-worker region_select; slot i occupies bits [16i+15:16i].
REQ-012 blk_counter  input  CNT_W*NUM_BLOCKS  per-worker result counter; slot i occupies bits [CNT_W*i+CNT_W-1:CNT_W*i].
REQ-013 blk_valid  input  NUM_BLOCKS  per-worker result-valid flag.
REQ-014 total  output  ACC_W  sum of all captured worker counters.
REQ-015 regions_done  output  17  number of regions captured in the current sweep.
REQ-016 busy  output  1  high while the sweep is in progress.
REQ-017 done  output  1  high while a completed sweep is being held.

Function
REQ-018 Top FSM states: IDLE, RUN, DONE; all outputs registered.
REQ-019 IDLE with start=1 sampled: latch first/last; next_region (17-bit) <= first; total and regions_done <= 0; go to RUN (or straight to DONE if first > last).
REQ-020 Each slot has its own FSM: S_IDLE, S_RUN, S_REL.
REQ-021 Dispatch, RUN only: at most one slot per cycle, lowest-index S_IDLE slot, and only when next_region <= last; blk_region[i] <= next_region[15:0]; blk_start[i] <= 1; slot -> S_RUN; next_region increments.
REQ-022 Capture: at most one slot per cycle, lowest-index slot in S_RUN with blk_valid[i]=1.
- total <= total + zero-extended blk_counter[i]; regions_done increments.
- blk_start[i] <= 0; slot -> S_REL.
- Unselected valid slots keep start high and wait; no result is lost.
REQ-023 S_REL holds blk_start[i]=0 for exactly 2 cycles, then S_IDLE; the slot may be redispatched in the following cycle.
REQ-024 Dispatch and capture on different slots in the same cycle are both performed; a slot captured this cycle is not dispatched this cycle.
REQ-025 blk_valid[i] while slot i is not in S_RUN is ignored.
REQ-026 next_region is 17 bits so region_last=16'hFFFF terminates without wrap-around.
REQ-027 RUN -> DONE when next_region > last and all slots are in S_IDLE.
REQ-028 DONE: done=1, busy=0, total/regions_done stable; DONE -> IDLE when start=0.
REQ-029 RUN with start=0: abort.
- All blk_start <= 0 and all slots -> S_REL, then S_IDLE.
- Top -> IDLE; done never asserts; total/regions_done keep partial values.
- A new start is accepted only after all slots are in S_IDLE.
REQ-030 busy=1 exactly while top state is RUN.
REQ-031 Latency: start sampled at edge k -> blk_start[0]=1 after edge k+1; slot i rises after edge k+1+i when all slots are free.
REQ-032 Accumulator does not saturate; ACC_W >= CNT_W+17 guarantees no overflow.

Reset
REQ-033 rst=1 at an edge forces top IDLE and all slots S_IDLE.
REQ-034 During reset: blk_start=0, blk_region=0, total=0, regions_done=0, next_region=0, busy=0, done=0.
REQ-035 rst overrides start, dispatch and capture in the same cycle, including reset in mid-sweep.

Verification
REQ-036 NUM_BLOCKS=4, behavioural workers return count=region mod 1024 after 20 cycles, first=0, last=9 -> 10 dispatches, each region dispatched exactly once, total=45, regions_done=10, done=1.
REQ-037 All 4 workers assert blk_valid in the same cycle -> captures on 4 consecutive cycles, order 0,1,2,3; no count lost.
REQ-038 first=5, last=4 -> DONE one cycle after start, total=0, no blk_start pulse.
REQ-039 first=16'hFFFE, last=16'hFFFF, counts 1023 each -> total=2046, regions_done=2, terminates without wrap.
REQ-040 start dropped with 3 regions in flight -> all blk_start low the next cycle, top IDLE, done stays 0, partial total retained.
REQ-041 rst asserted mid-sweep -> all outputs 0 after the next edge; a new sweep (first=0, last=3) then completes with total=6.
